// File: rtl/imem_loader.sv
// Streams 32-bit program words into a byte-wide, big-endian instruction memory.
// Each accepted word becomes four byte writes, MSB byte at the lowest address.
module imem_loader #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // state  | meaning
  // IDLE   | waiting for start; done/error pulse cycles also sit here
  // ACCEPT | in_ready high, waiting for the next program word
  // WR0-3  | writing byte n of the latched word to addr+n
  typedef enum logic [2:0] {IDLE, ACCEPT, WR0, WR1, WR2, WR3} state_t;

  localparam int SUM_W = ADDR_W + CNT_W + 2;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [23:0]       word_lo;
  logic [SUM_W-1:0]  end_addr;
  logic              overflow;

  // Wide enough that the end address can never wrap, so the whole load is checked up front.
  assign end_addr = SUM_W'(start_addr) + (SUM_W'(word_count) << 2);
  assign overflow = end_addr > SUM_W'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      word_lo   <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= word_count;
            if (start_addr[1:0] != 2'b00) begin
              error <= 1'b1;
            end else if (word_count == '0) begin
              done <= 1'b1;
            end else if (overflow) begin
              error <= 1'b1;
            end else begin
              state    <= ACCEPT;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            word_lo   <= in_word[23:0];
            state     <= WR0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= in_word[31:24];
          end
        end
        WR0: begin
          state     <= WR1;
          mem_addr  <= addr + ADDR_W'(1);
          mem_wdata <= word_lo[23:16];
        end
        WR1: begin
          state     <= WR2;
          mem_addr  <= addr + ADDR_W'(2);
          mem_wdata <= word_lo[15:8];
        end
        WR2: begin
          state     <= WR3;
          mem_addr  <= addr + ADDR_W'(3);
          mem_wdata <= word_lo[7:0];
        end
        WR3: begin
          mem_we    <= 1'b0;
          addr      <= addr + ADDR_W'(4);
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          mem_we   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load requests driven against a byte-write scoreboard,
// plus hand-written reset-abort and start-while-busy sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] start_addr;
  logic [11:0] word_count;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .word_count(word_count), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
    int          due;
  } wr_t;

  typedef struct {
    logic [13:0] addr;
    logic [11:0] cnt;
    bit          rnd;
    bit          mid_start;
    logic [31:0] base;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  wr_t         q[$];
  vec_t        vecs[8];
  logic [7:0]  tbmem[0:16383];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [13:0] exp_addr;
  int          hs_cnt, rdy_cnt, wr_cnt, done_cnt, err_cnt;
  int          first_hs, last_hs, last_we_cyc, pulse_cyc;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshakes seen at the edge turn into four expected byte writes, starting the next cycle.
  always @(posedge clk) begin
    cyc++;
    if (mon_en) begin
      if (in_ready) rdy_cnt++;
      if (in_valid && in_ready) begin
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
        for (int n = 0; n < 4; n++)
          q.push_back('{addr: exp_addr + 14'(n), data: in_word[31-8*n -: 8], due: cyc + n});
        exp_addr = exp_addr + 14'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we) begin
        wr_t e;
        wr_cnt++;
        last_we_cyc = cyc;
        tbmem[mem_addr] = mem_wdata;
        chk(q.size() != 0, "unexpected_write", {50'd0, mem_addr}, 64'd0);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk(mem_addr == e.addr && mem_wdata == e.data && cyc == e.due, "byte_write",
              {mem_addr, mem_wdata, 32'(cyc)}, {e.addr, e.data, 32'(e.due)});
        end
      end
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (done || error) begin
        pulse_cyc = cyc;
        chk(!(done && error) && !busy, "pulse_exclusive_idle", {done, error, busy}, 3'b000);
      end
    end
  end

  task automatic clear_counts();
    hs_cnt = 0; rdy_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0;
    first_hs = -1; last_hs = -1; last_we_cyc = -1; pulse_cyc = -1;
  endtask

  task automatic wait_hs(input int target, input bit rnd);
    bit ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (hs_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk(ok, "handshake_timeout", 64'(hs_cnt), 64'(target));
    if (rnd) in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit reject;
    int s_cyc;
    bit ok;
    reject = v.exp_err || (v.cnt == 12'd0);
    clear_counts();
    exp_addr   = v.addr;
    start      = 1'b1;
    start_addr = v.addr;
    word_count = v.cnt;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
    if (reject) begin
      in_valid = 1'b1;
      repeat (6) begin
        @(posedge clk); #1;
        chk(!busy && !in_ready, "reject_idle", {busy, in_ready}, 2'b00);
      end
      in_valid = 1'b0;
      chk(pulse_cyc == s_cyc, "reject_latency", 64'(pulse_cyc), 64'(s_cyc));
    end else begin
      for (int i = 0; i < int'(v.cnt); i++) begin
        in_word = (i == 0) ? v.base : v.base + 32'(i) * 32'h0102_0304;
        wait_hs(i + 1, v.rnd);
        if (v.mid_start && i == 0) begin
          start      = 1'b1;
          start_addr = 14'd2;
          word_count = 12'd7;
          @(posedge clk); #1;
          start      = 1'b0;
          start_addr = v.addr;
          word_count = v.cnt;
        end
      end
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        if (done_cnt > 0) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk); #1;
      end
      in_valid = 1'b0;
      chk(ok, "done_timeout", 64'(done_cnt), 64'd1);
      chk(pulse_cyc == last_we_cyc + 1, "done_after_last_write", 64'(pulse_cyc), 64'(last_we_cyc + 1));
      if (!v.rnd) begin
        chk(rdy_cnt == int'(v.cnt), "in_ready_cycles", 64'(rdy_cnt), 64'(v.cnt));
        chk(last_hs - first_hs == 5 * (int'(v.cnt) - 1), "word_spacing",
            64'(last_hs - first_hs), 64'(5 * (int'(v.cnt) - 1)));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk(done_cnt == int'(v.exp_done), "done_pulses", 64'(done_cnt), 64'(v.exp_done));
    chk(err_cnt == int'(v.exp_err), "error_pulses", 64'(err_cnt), 64'(v.exp_err));
    chk(q.size() == 0, "writes_outstanding", 64'(q.size()), 64'd0);
    chk(wr_cnt == (reject ? 0 : 4 * int'(v.cnt)), "write_count",
        64'(wr_cnt), 64'(reject ? 0 : 4 * int'(v.cnt)));
  endtask

  initial begin
    vecs[0] = '{14'd100,   12'd1, 1'b0, 1'b0, 32'h4808_0000, 1'b1, 1'b0};
    vecs[1] = '{14'd200,   12'd3, 1'b0, 1'b0, 32'hA1B2_C3D4, 1'b1, 1'b0};
    vecs[2] = '{14'd300,   12'd4, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0};
    vecs[3] = '{14'd102,   12'd1, 1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b1};
    vecs[4] = '{14'd16380, 12'd2, 1'b0, 1'b0, 32'h2222_2222, 1'b0, 1'b1};
    vecs[5] = '{14'd40,    12'd0, 1'b0, 1'b0, 32'h3333_3333, 1'b1, 1'b0};
    vecs[6] = '{14'd16380, 12'd1, 1'b0, 1'b0, 32'hCAFE_BABE, 1'b1, 1'b0};
    vecs[7] = '{14'd500,   12'd2, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; start_addr = '0; word_count = '0;
    in_valid = 1'b0; in_word = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk({in_ready, mem_we, busy, done, error, mem_addr, mem_wdata} == '0, "reset_state",
        {in_ready, mem_we, busy, done, error, mem_addr, mem_wdata}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k]);
      if (k == 0)
        chk({tbmem[100], tbmem[101], tbmem[102], tbmem[103]} == 32'h4808_0000, "fetch_readback",
            {tbmem[100], tbmem[101], tbmem[102], tbmem[103]}, 32'h4808_0000);
    end

    // Reset while the second word is in WR1: two of its bytes land, then the load is dropped.
    clear_counts();
    exp_addr = 14'd400; start = 1'b1; start_addr = 14'd400; word_count = 12'd3;
    @(posedge clk); #1;
    start   = 1'b0;
    in_word = 32'hDEAD_BEEF;
    wait_hs(1, 1'b0);
    in_word = 32'h5566_7788;
    wait_hs(2, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk(mem_we && mem_addr == 14'd405, "wr1_reached", {mem_we, mem_addr}, {1'b1, 14'd405});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({mem_we, busy, in_ready} == 3'b000, "reset_abort", {mem_we, busy, in_ready}, 3'b000);
    chk(q.size() == 2, "partial_writes_left", 64'(q.size()), 64'd2);
    q.delete();
    repeat (6) @(posedge clk);
    #1;
    chk(done_cnt == 0 && err_cnt == 0, "no_pulse_after_abort", {done_cnt[7:0], err_cnt[7:0]}, 16'd0);
    chk(wr_cnt == 6, "abort_write_count", 64'(wr_cnt), 64'd6);
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
